// File: rtl/approx_mul_rescale.sv
// approx_mul_rescale: back-end of the approximate multiplier.
// Takes two truncated mantissas plus the number of LSBs the front-end
// dropped from each, multiplies the mantissas with a fixed-latency
// shift-add engine, then shifts the product left by the total dropped
// bits to restore its magnitude. Results leave on a valid/ready handshake.
module approx_mul_rescale #(
    parameter int MW    = 8,
    parameter int SW    = 4,
    parameter int MAXSH = 8,
    parameter int PW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] mant_a,
    input  logic [MW-1:0] mant_b,
    input  logic [SW-1:0] shamt_a,
    input  logic [SW-1:0] shamt_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] product,
    output logic          clamp
);

    // Iteration counter only has to reach MW-1.
    localparam int CW = (MW > 1) ? $clog2(MW) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(MW - 1);

    // Saturation limit expressed at the width of the shift inputs.
    localparam logic [SW-1:0] MAXSH_S = SW'(MAXSH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;

    // Shift-add datapath: the multiplicand walks left inside a double-width
    // register while the multiplier walks right, one bit per cycle.
    logic [2*MW-1:0]  mcand;
    logic [MW-1:0]    mplier;
    logic [2*MW-1:0]  acc;
    logic [CW-1:0]    cnt;

    // Clamped per-operand shifts and the clamp flag for the in-flight result.
    logic [SW-1:0]    sa;
    logic [SW-1:0]    sb;
    logic             clamp_next;

    // Combinational helpers for capture and rescale.
    logic             over_a;
    logic             over_b;
    logic [SW-1:0]    sa_sat;
    logic [SW-1:0]    sb_sat;
    logic [SW:0]      shift_total;
    logic [PW-1:0]    acc_wide;

    assign over_a      = (shamt_a > MAXSH_S);
    assign over_b      = (shamt_b > MAXSH_S);
    assign sa_sat      = over_a ? MAXSH_S : shamt_a;
    assign sb_sat      = over_b ? MAXSH_S : shamt_b;

    // sa+sb never exceeds 2*MAXSH, so one extra bit holds the sum and the
    // PW-wide shift cannot lose any product bits.
    assign shift_total = {1'b0, sa} + {1'b0, sb};
    assign acc_wide    = {{(PW - 2*MW){1'b0}}, acc};

    // The block is ready exactly when idle, independent of in_valid.
    assign in_ready    = (state == IDLE);

    // Control FSM and datapath registers; reset aborts any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            sa         <= '0;
            sb         <= '0;
            clamp_next <= 1'b0;
            product    <= '0;
            clamp      <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand      <= {{MW{1'b0}}, mant_a};
                        mplier     <= mant_b;
                        sa         <= sa_sat;
                        sb         <= sb_sat;
                        clamp_next <= over_a | over_b;
                        acc        <= '0;
                        cnt        <= '0;
                        state      <= MUL;
                    end
                end

                MUL: begin
                    // Latency is fixed at MW iterations; a zero multiplier
                    // does not end the loop early.
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    product   <= acc_wide << shift_total;
                    clamp     <= clamp_next;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end

                DONE: begin
                    // product and clamp stay put after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mul_rescale.sv
// Self-checking bench for approx_mul_rescale: a scoreboard of expected
// results is filled as bundles are accepted and drained as results appear.
module tb_approx_mul_rescale;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  mant_a;
    logic [7:0]  mant_b;
    logic [3:0]  shamt_a;
    logic [3:0]  shamt_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        clamp;

    typedef struct packed {
        logic [31:0] prod;
        logic        clmp;
    } exp_t;

    exp_t sb_q[$];
    int   num_checks;
    int   num_errors;

    approx_mul_rescale #(
        .MW(8), .SW(4), .MAXSH(8), .PW(32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant_a    (mant_a),
        .mant_b    (mant_b),
        .shamt_a   (shamt_a),
        .shamt_b   (shamt_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .clamp     (clamp)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Wait (bounded) for the block to be idle, present one bundle for one
    // accepting edge and push the reference result onto the scoreboard.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] sa, input logic [3:0] sb);
        int          ea;
        int          eb;
        longint      full;
        exp_t        e;
        bit          seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("in_ready_wait", {63'd0, seen}, 64'd1);
        mant_a   = a;
        mant_b   = b;
        shamt_a  = sa;
        shamt_b  = sb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ea = (sa > 4'd8) ? 8 : int'(sa);
        eb = (sb > 4'd8) ? 8 : int'(sb);
        full = (longint'(a) * longint'(b)) << (ea + eb);
        e.prod = full[31:0];
        e.clmp = (sa > 4'd8) || (sb > 4'd8);
        sb_q.push_back(e);
    endtask

    // Wait for the result (bounded), check latency and value against the
    // scoreboard, optionally apply back-pressure with a stray bundle, then
    // complete the handshake and check the return to idle.
    task automatic collectResult(input string tag, input int hold_cycles);
        exp_t e;
        int   lat;
        bit   seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
        end
        checkOutput({tag, "_timeout"}, {63'd0, seen}, 64'd1);
        checkOutput({tag, "_latency"}, 64'(lat), 64'd9);
        if (sb_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 64'd0, 64'd1);
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        checkOutput({tag, "_product"}, {32'd0, product}, {32'd0, e.prod});
        checkOutput({tag, "_clamp"}, {63'd0, clamp}, {63'd0, e.clmp});
        for (int i = 0; i < hold_cycles; i++) begin
            mant_a   = 8'd1;
            mant_b   = 8'd1;
            shamt_a  = 4'd15;
            shamt_b  = 4'd15;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
            checkOutput({tag, "_hold_inready"}, {63'd0, in_ready}, 64'd0);
            checkOutput({tag, "_hold_product"}, {32'd0, product}, {32'd0, e.prod});
            checkOutput({tag, "_hold_clamp"}, {63'd0, clamp}, {63'd0, e.clmp});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_post_valid"}, {63'd0, out_valid}, 64'd0);
        checkOutput({tag, "_post_inready"}, {63'd0, in_ready}, 64'd1);
        checkOutput({tag, "_post_product"}, {32'd0, product}, {32'd0, e.prod});
    endtask

    // Main sequence.
    initial begin
        exp_t dropped;
        num_checks = 0;
        num_errors = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        mant_a     = '0;
        mant_b     = '0;
        shamt_a    = '0;
        shamt_b    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_inready", {63'd0, in_ready}, 64'd1);
        checkOutput("rst_outvalid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_product", {32'd0, product}, 64'd0);
        checkOutput("rst_clamp", {63'd0, clamp}, 64'd0);

        applyStimulus(8'd200, 8'd150, 4'd3, 4'd2);
        collectResult("basic", 0);
        checkOutput("basic_value", {32'd0, product}, 64'd960000);

        applyStimulus(8'd255, 8'd255, 4'd8, 4'd8);
        collectResult("maxrange", 0);
        checkOutput("maxrange_value", {32'd0, product}, 64'h0000_0000_FE01_0000);

        applyStimulus(8'd0, 8'd77, 4'd5, 4'd1);
        collectResult("zero", 0);
        checkOutput("zero_value", {32'd0, product}, 64'd0);

        applyStimulus(8'd10, 8'd10, 4'd12, 4'd0);
        collectResult("clamped", 0);
        checkOutput("clamped_value", {32'd0, product}, 64'd25600);
        checkOutput("clamped_flag", {63'd0, clamp}, 64'd1);

        applyStimulus(8'd123, 8'd45, 4'd2, 4'd9);
        collectResult("backpress", 5);
        applyStimulus(8'd17, 8'd33, 4'd4, 4'd0);
        collectResult("after_bp", 0);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            collectResult("random", 0);
        end

        applyStimulus(8'd99, 8'd98, 4'd1, 4'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        dropped = sb_q.pop_front();
        @(negedge clk);
        checkOutput("abort_outvalid", {63'd0, out_valid}, 64'd0);
        checkOutput("abort_product", {32'd0, product}, 64'd0);
        checkOutput("abort_inready", {63'd0, in_ready}, 64'd1);
        checkOutput("abort_clamp", {63'd0, clamp}, 64'd0);

        applyStimulus(8'd3, 8'd3, 4'd1, 4'd1);
        collectResult("post_abort", 0);
        checkOutput("post_abort_value", {32'd0, product}, 64'd36);

        checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/approx_mul_rescale.md
Name: approx_mul_rescale

Overview:
- Back-end of the approximate multiplier. The front-end truncates each 16-bit operand to a short mantissa and reports how many LSBs it dropped.
- This block accepts the two mantissas and their drop counts.
- It multiplies the mantissas with a sequential shift-add engine, then left-shifts the result by the total dropped bits to restore magnitude.
- It returns a 32-bit approximate product through a valid/ready handshake.

Parameters:
- MW, 8, mantissa width in bits (iterations of the shift-add loop)
- SW, 4, width of each shift-amount input
- MAXSH, 8, largest legal per-operand shift; larger inputs are clamped
- PW, 32, product output width (must be ≥ 2*MW + 2*MAXSH)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept a bundle
- mant_a  in  MW  truncated operand A
- mant_b  in  MW  truncated operand B
- shamt_a  in  SW  LSBs dropped from A
- shamt_b  in  SW  LSBs dropped from B
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  PW  approximate product
- clamp  out  1  a shift input exceeded MAXSH for this result

Behaviour:
- Reset (reset=1 at a clk edge) sets state=IDLE, in_ready=1, out_valid=0, product=0, clamp=0, and clears all internal registers.
- Reset has priority over every other event, including mid-MUL or DONE abort; the in-flight result is discarded.
- FSM states are IDLE, MUL, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, capture mant_a, mant_b, sa=min(shamt_a,MAXSH), sb=min(shamt_b,MAXSH).
  - Register clamp_next=(shamt_a>MAXSH)|(shamt_b>MAXSH).
  - Clear acc (2*MW bits), set cnt=0, go to MUL.
  - in_ready drops the cycle after acceptance.
- MUL, one iteration per cycle, MW cycles:
  - If multiplier LSB=1, acc += multiplicand.
  - Multiplicand shifts left 1; multiplier shifts right 1; cnt++.
  - After the iteration with cnt=MW-1, go to SHIFT.
  - No early exit on a zero multiplier; latency is fixed.
- SHIFT, one cycle:
  - product <= zero-extend(acc) << (sa+sb); sa+sb ≤ 2*MAXSH, so no bits are lost.
  - clamp <= clamp_next; out_valid <= 1; go to DONE.
- DONE:
  - product and clamp are held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid <= 0, go to IDLE; in_ready=1 on the following cycle.
  - product keeps its last value after handshake; do not clear it.
- Latency: bundle accepted at edge E0; out_valid=1 after edge E0+MW+1 (9 edges with defaults).
- Throughput: one result per MW+3 cycles minimum when out_ready is held at 1.
- in_valid while not IDLE is ignored; inputs are not sampled and the source must hold them.
- out_ready while out_valid=0 has no effect.
- Arithmetic is unsigned throughout.
- mant=0 on either side gives product=0 after full latency; clamp still reflects shift inputs.
- The only combinational output is in_ready=(state==IDLE); it is not gated by in_valid.

Test Plan:
- Reset then mant_a=200, mant_b=150, shamt_a=3, shamt_b=2, out_ready=1 → out_valid high exactly 9 edges after accept; product=960000 (30000<<5); clamp=0; in_ready returns to 1 the cycle after handshake.
- mant_a=255, mant_b=255, shamt_a=8, shamt_b=8 → product=0xFE010000, clamp=0 (max range, no overflow).
- mant_a=0, mant_b=77, shamt_a=5, shamt_b=1 → product=0 after full 9-edge latency.
- mant_a=10, mant_b=10, shamt_a=12, shamt_b=0 → shift clamped to 8; product=25600; clamp=1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid → product/clamp stable, in_ready=0, new in_valid ignored. Then pulse out_ready → IDLE; next bundle accepted correctly.
- Assert reset 4 cycles into MUL → next cycle out_valid=0, product=0, in_ready=1. A following bundle (3×3, shifts 1,1) yields 36.
